// File: rtl/mult_err_char_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_char_pkg
// Purpose  : Shared definitions for the multiplier error-characterisation
//            engine: sweep state encoding, width helpers, latency limit.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mult_err_char_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Deepest DUT pipeline the operand delay line is meant to cover.
  localparam int c_MAX_DUT_LAT = 4;

  // Product width (PW) and error-sum width (SW) for a given operand width.
  function automatic int pw_of(input int width);
    return 2 * width;
  endfunction

  function automatic int sw_of(input int width);
    return 4 * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_err_char_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_char_if
// Purpose  : Operand/result bus between the characterisation engine and the
//            multiplier under test.
// Ports    : A, B  operands (initiator -> multiplier)
//            R     product   (multiplier -> initiator)
//            master modport = engine side, slave modport = multiplier side
// Revision : 1.0  initial release
// ============================================================================
interface mult_err_char_if
  import mult_err_char_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]        A;
  logic [WIDTH-1:0]        B;
  logic [pw_of(WIDTH)-1:0] R;

  modport master (output A, output B, input R);
  modport slave  (input A, input B, output R);

endinterface
`default_nettype wire

// File: rtl/mult_err_char_acc.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_char_acc
// Purpose  : Compare register stage plus error accumulators. Captures R with
//            its aligned operands, then on the next edge folds |R - A*B| into
//            the error count, error sum and first-worst-case tracker.
// Ports    : clk, rst        clock, synchronous active-high reset
//            i_clr           synchronous clear of compare stage + results
//            i_vld           i_a/i_b/i_r form a pair to be compared
//            i_a, i_b, i_r   aligned operands and multiplier result
//            o_err_cnt       pairs with a nonzero error
//            o_err_sum       sum of absolute errors
//            o_err_max       largest absolute error
//            o_max_a/o_max_b first pair that reached o_err_max
// Revision : 1.0  initial release
// ============================================================================
module mult_err_char_acc
  import mult_err_char_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      i_clr,
  input  wire logic                      i_vld,
  input  wire logic [WIDTH-1:0]          i_a,
  input  wire logic [WIDTH-1:0]          i_b,
  input  wire logic [pw_of(WIDTH)-1:0]   i_r,
  output logic      [pw_of(WIDTH):0]     o_err_cnt,
  output logic      [sw_of(WIDTH)-1:0]   o_err_sum,
  output logic      [pw_of(WIDTH)-1:0]   o_err_max,
  output logic      [WIDTH-1:0]          o_max_a,
  output logic      [WIDTH-1:0]          o_max_b
);

  localparam int c_PW = pw_of(WIDTH);
  localparam int c_SW = sw_of(WIDTH);

  // Compare stage
  logic                r_cmp_vld;
  logic [WIDTH-1:0]    r_cmp_a;
  logic [WIDTH-1:0]    r_cmp_b;
  logic [c_PW-1:0]     r_cmp_r;

  // Accumulators
  logic [c_PW:0]       r_err_cnt;
  logic [c_SW-1:0]     r_err_sum;
  logic [c_PW-1:0]     r_err_max;
  logic [WIDTH-1:0]    r_max_a;
  logic [WIDTH-1:0]    r_max_b;

  logic [c_PW-1:0]     w_exact;
  logic signed [c_PW:0] w_diff;
  logic [c_PW-1:0]     w_mag;

  // R is only captured inside the compare window, so an undriven R while the
  // engine is idle never reaches the accumulators.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cmp_vld <= 1'b0;
      r_cmp_a   <= '0;
      r_cmp_b   <= '0;
      r_cmp_r   <= '0;
    end else begin
      r_cmp_vld <= i_vld;
      if (i_vld) begin
        r_cmp_a <= i_a;
        r_cmp_b <= i_b;
        r_cmp_r <= i_r;
      end
    end
  end

  assign w_exact = {{WIDTH{1'b0}}, r_cmp_a} * {{WIDTH{1'b0}}, r_cmp_b};
  // One extra bit keeps R - exact representable in both directions; the
  // magnitude of that difference always fits back into c_PW bits.
  assign w_diff  = $signed({1'b0, r_cmp_r}) - $signed({1'b0, w_exact});
  assign w_mag   = w_diff[c_PW] ? c_PW'(-w_diff) : c_PW'(w_diff);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
    end else if (r_cmp_vld) begin
      if (w_mag != '0) begin
        r_err_cnt <= r_err_cnt + {{c_PW{1'b0}}, 1'b1};
      end
      r_err_sum <= r_err_sum + {{(c_SW-c_PW){1'b0}}, w_mag};
      // Strictly greater: ties keep the earliest pair in sweep order.
      if (w_mag > r_err_max) begin
        r_err_max <= w_mag;
        r_max_a   <= r_cmp_a;
        r_max_b   <= r_cmp_b;
      end
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign o_err_sum = r_err_sum;
  assign o_err_max = r_err_max;
  assign o_max_a   = r_max_a;
  assign o_max_b   = r_max_b;

endmodule
`default_nettype wire

// File: rtl/mult_err_char.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_char
// Purpose  : Error-characterisation engine for a WIDTHxWIDTH multiplier.
//            Sweeps every operand pair (B fastest), aligns the operands to the
//            multiplier latency and scores R against the exact product.
// Ports    : clk, rst   clock, synchronous active-high reset
//            start      one-cycle sweep request, honoured only when idle
//            mbus       A/B out, R in (master side of the multiplier bus)
//            busy       high while sweeping or draining
//            done       one-cycle pulse when results are final
//            err_cnt, err_sum, err_max, max_A, max_B  sweep results
// Revision : 1.0  initial release
// ============================================================================
module mult_err_char
  import mult_err_char_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DUT_LAT = 0
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    start,
  mult_err_char_if.master              mbus,
  output logic                         busy,
  output logic                         done,
  output logic [pw_of(WIDTH):0]        err_cnt,
  output logic [sw_of(WIDTH)-1:0]      err_sum,
  output logic [pw_of(WIDTH)-1:0]      err_max,
  output logic [WIDTH-1:0]             max_A,
  output logic [WIDTH-1:0]             max_B
);

  localparam int       c_PW         = pw_of(WIDTH);
  // The drain counter stops once the last pair has left the accumulator.
  localparam logic [2:0] c_DRAIN_LAST = 3'(DUT_LAT + 1);

  if (DUT_LAT < 0 || DUT_LAT > c_MAX_DUT_LAT) begin : g_lat_check
    $error("mult_err_char: DUT_LAT outside supported range");
  end

  state_t              r_state;
  logic [c_PW-1:0]     r_idx;
  logic [2:0]          r_drain_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_iss_vld;
  logic                r_busy;
  logic                r_done;

  logic                w_clr;
  logic [WIDTH-1:0]    w_dly_a;
  logic [WIDTH-1:0]    w_dly_b;
  logic                w_dly_vld;

  // Accumulators are cleared on the very edge that accepts start.
  assign w_clr = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_iss_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_iss_vld <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SWEEP;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          r_a       <= r_idx[c_PW-1:WIDTH];
          r_b       <= r_idx[WIDTH-1:0];
          r_iss_vld <= 1'b1;
          r_idx     <= r_idx + {{(c_PW-1){1'b0}}, 1'b1};
          if (r_idx == '1) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == c_DRAIN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand delay line: pairs the operands with the R they produced.
  if (DUT_LAT == 0) begin : g_no_dly
    assign w_dly_a   = r_a;
    assign w_dly_b   = r_b;
    assign w_dly_vld = r_iss_vld;
  end else begin : g_dly
    logic [WIDTH-1:0] r_pipe_a   [DUT_LAT];
    logic [WIDTH-1:0] r_pipe_b   [DUT_LAT];
    logic             r_pipe_vld [DUT_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DUT_LAT; i++) begin
          r_pipe_a[i]   <= '0;
          r_pipe_b[i]   <= '0;
          r_pipe_vld[i] <= 1'b0;
        end
      end else begin
        r_pipe_a[0]   <= r_a;
        r_pipe_b[0]   <= r_b;
        r_pipe_vld[0] <= r_iss_vld;
        for (int i = 1; i < DUT_LAT; i++) begin
          r_pipe_a[i]   <= r_pipe_a[i-1];
          r_pipe_b[i]   <= r_pipe_b[i-1];
          r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
      end
    end

    assign w_dly_a   = r_pipe_a[DUT_LAT-1];
    assign w_dly_b   = r_pipe_b[DUT_LAT-1];
    assign w_dly_vld = r_pipe_vld[DUT_LAT-1];
  end

  mult_err_char_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_vld     (w_dly_vld),
    .i_a       (w_dly_a),
    .i_b       (w_dly_b),
    .i_r       (mbus.R),
    .o_err_cnt (err_cnt),
    .o_err_sum (err_sum),
    .o_err_max (err_max),
    .o_max_a   (max_A),
    .o_max_b   (max_B)
  );

  assign mbus.A = r_a;
  assign mbus.B = r_b;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire
